// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: tag width, depth, bus widths,
// opcode encodings and opcode-class helpers.
package reorder_buffer_pkg;

  localparam int unsigned ROB_AW    = 4;
  localparam int unsigned ROB_DEPTH = 1 << ROB_AW;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned REG_W     = 5;

  typedef logic [ROB_AW-1:0] rob_tag_t;

  // Decoded opcode encodings carried on the dispatch OpBus.
  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd21;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd22;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd23;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd24;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd25;
  localparam logic [OP_W-1:0] OP_AND   = 6'd26;
  localparam logic [OP_W-1:0] OP_OR    = 6'd27;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd28;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic is_jump(input logic [OP_W-1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures ALU/LSB
// results out of order, commits one entry per cycle from head, and flushes
// everything when a committing branch/jump was mispredicted.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                disp_valid,
  input  logic [OP_W-1:0]     disp_op,
  input  logic [REG_W-1:0]    disp_rd,
  input  logic [ADDR_W-1:0]   disp_pc,
  input  logic                disp_pred,
  output logic [ROB_AW-1:0]   ROB_nxtpos,
  output logic                rob_full,
  input  logic [ROB_AW-1:0]   q1_tag,
  input  logic [ROB_AW-1:0]   q2_tag,
  output logic                q1_ready,
  output logic                q2_ready,
  output logic [DATA_W-1:0]   q1_value,
  output logic [DATA_W-1:0]   q2_value,
  input  logic                alu_valid,
  input  logic [ROB_AW-1:0]   alu_tag,
  input  logic [DATA_W-1:0]   alu_value,
  input  logic                alu_taken,
  input  logic [ADDR_W-1:0]   alu_target,
  input  logic                lsb_valid,
  input  logic [ROB_AW-1:0]   lsb_tag,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                commit_valid,
  output logic [REG_W-1:0]    commit_rd,
  output logic [DATA_W-1:0]   commit_value,
  output logic [ROB_AW-1:0]   commit_tag,
  output logic                store_commit,
  output logic                flush_out,
  output logic [ADDR_W-1:0]   flush_pc
);

  localparam logic [ROB_AW-1:0] TAG_ONE  = 1;
  localparam logic [ROB_AW:0]   CNT_ONE  = 1;
  localparam logic [ROB_AW:0]   CNT_FULL = ROB_DEPTH[ROB_AW:0];

  // Pointers and occupancy; count is one bit wider than the tags so that
  // full and empty stay distinguishable when head == tail.
  logic [ROB_AW-1:0]    r_head;
  logic [ROB_AW-1:0]    r_tail;
  logic [ROB_AW:0]      r_count;

  // Per-entry state
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_ready;
  logic [ROB_DEPTH-1:0] r_pred;
  logic [ROB_DEPTH-1:0] r_taken;
  logic [OP_W-1:0]      r_op     [ROB_DEPTH];
  logic [REG_W-1:0]     r_rd     [ROB_DEPTH];
  logic [ADDR_W-1:0]    r_pc     [ROB_DEPTH];
  logic [DATA_W-1:0]    r_value  [ROB_DEPTH];
  logic [ADDR_W-1:0]    r_target [ROB_DEPTH];

  // Registered commit/flush outputs
  logic                 r_commit_valid;
  logic [REG_W-1:0]     r_commit_rd;
  logic [DATA_W-1:0]    r_commit_value;
  logic [ROB_AW-1:0]    r_commit_tag;
  logic                 r_store_commit;
  logic                 r_flush;
  logic [ADDR_W-1:0]    r_flush_pc;

  logic [OP_W-1:0]      w_head_op;
  logic                 w_head_store;
  logic                 w_head_jump;
  logic                 w_head_ctrl;
  logic [ADDR_W-1:0]    w_head_pc4;
  logic                 w_commit;
  logic                 w_flush;
  logic                 w_alloc;
  logic                 w_alu_wr;
  logic                 w_lsb_wr;

  assign w_head_op    = r_op[r_head];
  assign w_head_store = is_store(w_head_op);
  assign w_head_jump  = is_jump(w_head_op);
  assign w_head_ctrl  = is_branch(w_head_op) || w_head_jump;
  assign w_head_pc4   = r_pc[r_head] + 32'd4;

  assign rob_full   = (r_count == CNT_FULL);
  assign ROB_nxtpos = r_tail;

  // Commit is decided from registered entry state only, so a result
  // written on one edge can commit no earlier than the following edge.
  assign w_commit = rdy_in && r_valid[r_head] && r_ready[r_head];
  assign w_flush  = w_commit && w_head_ctrl && (r_taken[r_head] != r_pred[r_head]);
  assign w_alloc  = rdy_in && disp_valid && !rob_full && !w_flush;
  assign w_alu_wr = rdy_in && alu_valid && r_valid[alu_tag];
  assign w_lsb_wr = rdy_in && lsb_valid && r_valid[lsb_tag];

  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign commit_tag   = r_commit_tag;
  assign store_commit = r_store_commit;
  assign flush_out    = r_flush;
  assign flush_pc     = r_flush_pc;

  // Pointer, occupancy and valid/ready bookkeeping; a flush wipes all of it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
        r_ready <= '0;
      end else begin
        // Later assignments win: commit clears the head after any same-edge
        // writeback, and allocation never targets a live entry.
        if (w_lsb_wr) r_ready[lsb_tag] <= 1'b1;
        if (w_alu_wr) r_ready[alu_tag] <= 1'b1;
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + TAG_ONE;
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + TAG_ONE;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_alloc) begin
        r_op[r_tail]   <= disp_op;
        r_rd[r_tail]   <= disp_rd;
        r_pc[r_tail]   <= disp_pc;
        r_pred[r_tail] <= disp_pred;
      end
      if (w_lsb_wr) r_value[lsb_tag] <= lsb_value;
      if (w_alu_wr) begin
        r_value[alu_tag]  <= alu_value;
        r_taken[alu_tag]  <= alu_taken;
        r_target[alu_tag] <= alu_target;
      end
    end
  end

  // Commit/flush outputs: one-cycle pulses, data held between commits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_tag   <= '0;
      r_store_commit <= 1'b0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
    end else if (w_commit) begin
      r_commit_valid <= !w_head_store && (r_rd[r_head] != '0);
      r_commit_rd    <= r_rd[r_head];
      r_commit_value <= w_head_jump ? w_head_pc4 : r_value[r_head];
      r_commit_tag   <= r_head;
      r_store_commit <= w_head_store;
      r_flush        <= w_flush;
      if (w_flush) r_flush_pc <= r_taken[r_head] ? r_target[r_head] : w_head_pc4;
    end else begin
      r_commit_valid <= 1'b0;
      r_store_commit <= 1'b0;
      r_flush        <= 1'b0;
    end
  end

  // Operand query 1: stored result, else same-cycle bus bypass (ALU wins).
  always_comb begin
    q1_ready = r_valid[q1_tag] && r_ready[q1_tag];
    q1_value = r_value[q1_tag];
    if (lsb_valid && (lsb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_value = lsb_value;
    end
    if (alu_valid && (alu_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_value = alu_value;
    end
  end

  // Operand query 2: same resolution as query 1.
  always_comb begin
    q2_ready = r_valid[q2_tag] && r_ready[q2_tag];
    q2_value = r_value[q2_tag];
    if (lsb_valid && (lsb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_value = lsb_value;
    end
    if (alu_valid && (alu_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_value = alu_value;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued as
// results are driven and checked against each commit/store/flush pulse.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                clk_in;
  logic                rst_n_in;
  logic                rdy_in;
  logic                disp_valid;
  logic [OP_W-1:0]     disp_op;
  logic [REG_W-1:0]    disp_rd;
  logic [ADDR_W-1:0]   disp_pc;
  logic                disp_pred;
  logic [ROB_AW-1:0]   ROB_nxtpos;
  logic                rob_full;
  logic [ROB_AW-1:0]   q1_tag, q2_tag;
  logic                q1_ready, q2_ready;
  logic [DATA_W-1:0]   q1_value, q2_value;
  logic                alu_valid;
  logic [ROB_AW-1:0]   alu_tag;
  logic [DATA_W-1:0]   alu_value;
  logic                alu_taken;
  logic [ADDR_W-1:0]   alu_target;
  logic                lsb_valid;
  logic [ROB_AW-1:0]   lsb_tag;
  logic [DATA_W-1:0]   lsb_value;
  logic                commit_valid;
  logic [REG_W-1:0]    commit_rd;
  logic [DATA_W-1:0]   commit_value;
  logic [ROB_AW-1:0]   commit_tag;
  logic                store_commit;
  logic                flush_out;
  logic [ADDR_W-1:0]   flush_pc;

  typedef struct {
    logic        st;
    logic        cv;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  tag;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_pred(disp_pred),
    .ROB_nxtpos(ROB_nxtpos), .rob_full(rob_full),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .store_commit(store_commit),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Commit monitor: every pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_n_in && (commit_valid || store_commit || flush_out)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_commit got cv=%b st=%b fl=%b tag=%0d rd=%0d val=%h, expected no commit",
                 commit_valid, store_commit, flush_out, commit_tag, commit_rd, commit_value);
      end else begin
        e = sb.pop_front();
        if (commit_valid !== e.cv || store_commit !== e.st || flush_out !== e.fl ||
            commit_tag !== e.tag || commit_rd !== e.rd ||
            (e.cv && commit_value !== e.val) || (e.fl && flush_pc !== e.fpc)) begin
          n_err++;
          $display("FAIL commit_sb got cv=%b st=%b fl=%b tag=%0d rd=%0d val=%h fpc=%h expected cv=%b st=%b fl=%b tag=%0d rd=%0d val=%h fpc=%h",
                   commit_valid, store_commit, flush_out, commit_tag, commit_rd, commit_value, flush_pc,
                   e.cv, e.st, e.fl, e.tag, e.rd, e.val, e.fpc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op, input logic [4:0] rd,
                          input logic [31:0] pc, input logic pred);
    disp_valid = 1'b1; disp_op = op; disp_rd = rd; disp_pc = pc; disp_pred = pred;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b1;
    #2 rst_n_in = 1'b0;
    #2;
    n_vec++;
    if (ROB_nxtpos !== 4'd0 || rob_full !== 1'b0) begin
      n_err++; $display("FAIL reset_ptr got nxtpos=%0d full=%b expected 0 0", ROB_nxtpos, rob_full);
    end
    n_vec++;
    if (commit_valid !== 1'b0 || store_commit !== 1'b0 || flush_out !== 1'b0 ||
        commit_rd !== 5'd0 || commit_value !== 32'd0 || commit_tag !== 4'd0 || flush_pc !== 32'd0) begin
      n_err++; $display("FAIL reset_out got cv=%b st=%b fl=%b rd=%0d val=%h tag=%0d fpc=%h expected all 0",
                        commit_valid, store_commit, flush_out, commit_rd, commit_value, commit_tag, flush_pc);
    end
    n_vec++;
    if (q1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_query got q1_ready=%b expected 0", q1_ready);
    end
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic test_basic();
    n_vec++;
    if (ROB_nxtpos !== 4'd0) begin n_err++; $display("FAIL basic_nxtpos0 got %0d expected 0", ROB_nxtpos); end
    dispatch(OP_ADDI, 5'd5, 32'h100, 1'b0);
    n_vec++;
    if (ROB_nxtpos !== 4'd1) begin n_err++; $display("FAIL basic_nxtpos1 got %0d expected 1", ROB_nxtpos); end
    sb.push_back('{st:1'b0, cv:1'b1, rd:5'd5, val:32'd7, tag:4'd0, fl:1'b0, fpc:32'd0});
    alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'd7; alu_taken = 1'b0;
    tick();
    alu_valid = 1'b0;
    n_vec++;
    if (commit_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got cv=%b expected 0", commit_valid); end
    tick();
    n_vec++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'd7 || commit_tag !== 4'd0) begin
      n_err++; $display("FAIL basic_commit got cv=%b rd=%0d val=%h tag=%0d expected 1 5 7 0",
                        commit_valid, commit_rd, commit_value, commit_tag);
    end
    tick();
    n_vec++;
    if (commit_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse got cv=%b expected 0", commit_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) dispatch(OP_ADDI, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
    n_vec++;
    if (rob_full !== 1'b1 || ROB_nxtpos !== 4'd0) begin
      n_err++; $display("FAIL full_set got full=%b nxtpos=%0d expected 1 0", rob_full, ROB_nxtpos);
    end
    dispatch(OP_ADDI, 5'd31, 32'h2000, 1'b0);
    n_vec++;
    if (rob_full !== 1'b1 || ROB_nxtpos !== 4'd0) begin
      n_err++; $display("FAIL full_ignore got full=%b nxtpos=%0d expected 1 0", rob_full, ROB_nxtpos);
    end
    sb.push_back('{st:1'b0, cv:1'b1, rd:5'd1, val:32'h55, tag:4'd0, fl:1'b0, fpc:32'd0});
    alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'h55; alu_taken = 1'b0;
    tick();
    alu_valid = 1'b0;
    tick();
    n_vec++;
    if (rob_full !== 1'b0 || ROB_nxtpos !== 4'd0) begin
      n_err++; $display("FAIL full_clear got full=%b nxtpos=%0d expected 0 0", rob_full, ROB_nxtpos);
    end
    dispatch(OP_ADDI, 5'd30, 32'h2004, 1'b0);
    n_vec++;
    if (rob_full !== 1'b1 || ROB_nxtpos !== 4'd1) begin
      n_err++; $display("FAIL full_wrap got full=%b nxtpos=%0d expected 1 1", rob_full, ROB_nxtpos);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch(OP_ADDI, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b0);
      sb.push_back('{st:1'b0, cv:1'b1, rd:5'(i + 1), val:32'h10 + 32'(i), tag:4'(i), fl:1'b0, fpc:32'd0});
    end
    alu_valid = 1'b1; alu_tag = 4'd2; alu_value = 32'h12; alu_taken = 1'b0;
    tick();
    alu_valid = 1'b0;
    lsb_valid = 1'b1; lsb_tag = 4'd0; lsb_value = 32'h10;
    tick();
    lsb_valid = 1'b0;
    alu_valid = 1'b1; alu_tag = 4'd1; alu_value = 32'h11;
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (commit_valid !== 1'b1 || commit_tag !== 4'(i)) begin
        n_err++; $display("FAIL ooo_order%0d got cv=%b tag=%0d expected 1 %0d", i, commit_valid, commit_tag, i);
      end
      tick();
    end
    n_vec++;
    if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_after got cv=%b expected 0", commit_valid); end
  endtask

  task automatic test_query_bypass();
    dispatch(OP_ADDI, 5'd7, 32'h140, 1'b0);
    q1_tag = 4'd3; q2_tag = 4'd4;
    #1;
    n_vec++;
    if (q1_ready !== 1'b0) begin n_err++; $display("FAIL query_pending got q1_ready=%b expected 0", q1_ready); end
    alu_valid = 1'b1; alu_tag = 4'd3; alu_value = 32'hDEAD; alu_taken = 1'b0;
    lsb_valid = 1'b1; lsb_tag = 4'd4; lsb_value = 32'hBEEF;
    #1;
    n_vec++;
    if (q1_ready !== 1'b1 || q1_value !== 32'hDEAD) begin
      n_err++; $display("FAIL query_alu_bypass got ready=%b val=%h expected 1 0000dead", q1_ready, q1_value);
    end
    n_vec++;
    if (q2_ready !== 1'b1 || q2_value !== 32'hBEEF) begin
      n_err++; $display("FAIL query_lsb_bypass got ready=%b val=%h expected 1 0000beef", q2_ready, q2_value);
    end
    sb.push_back('{st:1'b0, cv:1'b1, rd:5'd7, val:32'hDEAD, tag:4'd3, fl:1'b0, fpc:32'd0});
    tick();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    #1;
    n_vec++;
    if (q1_ready !== 1'b1 || q1_value !== 32'hDEAD) begin
      n_err++; $display("FAIL query_stored got ready=%b val=%h expected 1 0000dead", q1_ready, q1_value);
    end
    n_vec++;
    if (q2_ready !== 1'b0) begin n_err++; $display("FAIL query_invalid_wb got q2_ready=%b expected 0", q2_ready); end
    tick();
    tick();
  endtask

  task automatic test_mispredict();
    do_reset();
    dispatch(OP_BEQ, 5'd0, 32'h300, 1'b0);
    dispatch(OP_ADDI, 5'd2, 32'h304, 1'b0);
    dispatch(OP_ADDI, 5'd3, 32'h308, 1'b0);
    sb.push_back('{st:1'b0, cv:1'b0, rd:5'd0, val:32'd0, tag:4'd0, fl:1'b1, fpc:32'h200});
    alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'd0; alu_taken = 1'b1; alu_target = 32'h200;
    tick();
    // flush cycle: this writeback and allocation must be dropped
    alu_tag = 4'd1; alu_value = 32'h99; alu_taken = 1'b0;
    disp_valid = 1'b1; disp_op = OP_ADDI; disp_rd = 5'd4; disp_pc = 32'h30C; disp_pred = 1'b0;
    tick();
    alu_valid = 1'b0; disp_valid = 1'b0;
    n_vec++;
    if (flush_out !== 1'b1 || flush_pc !== 32'h200 || commit_valid !== 1'b0) begin
      n_err++; $display("FAIL mp_flush got fl=%b fpc=%h cv=%b expected 1 00000200 0", flush_out, flush_pc, commit_valid);
    end
    n_vec++;
    if (ROB_nxtpos !== 4'd0 || rob_full !== 1'b0) begin
      n_err++; $display("FAIL mp_cleared got nxtpos=%0d full=%b expected 0 0", ROB_nxtpos, rob_full);
    end
    q1_tag = 4'd1;
    tick();
    n_vec++;
    if (flush_out !== 1'b0 || q1_ready !== 1'b0) begin
      n_err++; $display("FAIL mp_after got fl=%b q1_ready=%b expected 0 0", flush_out, q1_ready);
    end
    for (int i = 0; i < 3; i++) tick();

    dispatch(OP_JALR, 5'd1, 32'h500, 1'b0);
    sb.push_back('{st:1'b0, cv:1'b1, rd:5'd1, val:32'h504, tag:4'd0, fl:1'b1, fpc:32'h400});
    alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'd0; alu_taken = 1'b1; alu_target = 32'h400;
    tick();
    alu_valid = 1'b0;
    tick();
    n_vec++;
    if (flush_out !== 1'b1 || flush_pc !== 32'h400 || commit_valid !== 1'b1 || commit_value !== 32'h504) begin
      n_err++; $display("FAIL mp_jalr got fl=%b fpc=%h cv=%b val=%h expected 1 00000400 1 00000504",
                        flush_out, flush_pc, commit_valid, commit_value);
    end
    tick();

    dispatch(OP_BNE, 5'd0, 32'h600, 1'b1);
    sb.push_back('{st:1'b0, cv:1'b0, rd:5'd0, val:32'd0, tag:4'd0, fl:1'b1, fpc:32'h604});
    alu_valid = 1'b1; alu_tag = 4'd0; alu_value = 32'd0; alu_taken = 1'b0; alu_target = 32'h900;
    tick();
    alu_valid = 1'b0;
    tick();
    n_vec++;
    if (flush_out !== 1'b1 || flush_pc !== 32'h604) begin
      n_err++; $display("FAIL mp_nottaken got fl=%b fpc=%h expected 1 00000604", flush_out, flush_pc);
    end
    tick();
  endtask

  task automatic test_store_rdy();
    do_reset();
    dispatch(OP_SW, 5'd0, 32'h700, 1'b0);
    sb.push_back('{st:1'b1, cv:1'b0, rd:5'd0, val:32'd0, tag:4'd0, fl:1'b0, fpc:32'd0});
    lsb_valid = 1'b1; lsb_tag = 4'd0; lsb_value = 32'h800;
    tick();
    lsb_valid = 1'b0;
    rdy_in = 1'b0;
    disp_valid = 1'b1; disp_op = OP_ADDI; disp_rd = 5'd8; disp_pc = 32'h704; disp_pred = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (store_commit !== 1'b0 || ROB_nxtpos !== 4'd1) begin
        n_err++; $display("FAIL rdy_low%0d got st=%b nxtpos=%0d expected 0 1", i, store_commit, ROB_nxtpos);
      end
    end
    disp_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    n_vec++;
    if (store_commit !== 1'b1 || commit_valid !== 1'b0) begin
      n_err++; $display("FAIL store_commit got st=%b cv=%b expected 1 0", store_commit, commit_valid);
    end
    tick();
    n_vec++;
    if (store_commit !== 1'b0) begin n_err++; $display("FAIL store_pulse got st=%b expected 0", store_commit); end

    dispatch(OP_ADDI, 5'd9, 32'h710, 1'b0);
    dispatch(OP_ADDI, 5'd10, 32'h714, 1'b0);
    sb.push_back('{st:1'b0, cv:1'b1, rd:5'd9, val:32'h77, tag:4'd1, fl:1'b0, fpc:32'd0});
    alu_valid = 1'b1; alu_tag = 4'd1; alu_value = 32'h77; alu_taken = 1'b0;
    tick();
    alu_tag = 4'd2; alu_value = 32'h78;
    tick();
    alu_valid = 1'b0;
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    n_vec++;
    if (commit_valid !== 1'b0 || commit_rd !== 5'd0 || commit_value !== 32'd0 || commit_tag !== 4'd0 ||
        store_commit !== 1'b0 || flush_out !== 1'b0 || ROB_nxtpos !== 4'd0) begin
      n_err++; $display("FAIL async_reset got cv=%b rd=%0d val=%h tag=%0d st=%b fl=%b nxtpos=%0d expected all 0",
                        commit_valid, commit_rd, commit_value, commit_tag, store_commit, flush_out, ROB_nxtpos);
    end
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst_n_in = 1'b1; rdy_in = 1'b1;
    disp_valid = 1'b0; disp_op = OP_NOP; disp_rd = '0; disp_pc = '0; disp_pred = 1'b0;
    q1_tag = '0; q2_tag = '0;
    alu_valid = 1'b0; alu_tag = '0; alu_value = '0; alu_taken = 1'b0; alu_target = '0;
    lsb_valid = 1'b0; lsb_tag = '0; lsb_value = '0;

    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_query_bypass();
    test_mispredict();
    test_store_rdy();

    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain got %0d outstanding commits expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
